// File: rtl/prince_pkg.sv
// Shared constants and types for the serialized PRINCE substitution layer.
// The S-box tables are packed so that nibble i of the constant is the
// substitution of input value i.
package prince_pkg;

    localparam int STATE_W = 64;
    localparam int NIB_W   = 4;

    // Forward S-box: 0..F -> B F 3 2 A C 9 1 6 7 8 0 E 5 D 4
    localparam logic [63:0] SBOX_FWD = 64'h4D5E_0876_19CA_23FB;
    // Inverse S-box: 0..F -> B 7 3 2 F D 8 9 A 6 4 0 5 E C 1
    localparam logic [63:0] SBOX_INV = 64'h1CE5_046A_98DF_237B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Pick the 4-bit entry for a nibble out of a packed 16-entry table.
    function automatic logic [NIB_W-1:0] sbox_lookup(input logic [63:0] tbl,
                                                     input logic [NIB_W-1:0] nib);
        return tbl[{nib, 2'b00} +: NIB_W];
    endfunction

endpackage

// File: rtl/prince_sbox_dual.sv
// 4-bit combinational PRINCE S-box with forward/inverse select.
module prince_sbox_dual
    import prince_pkg::*;
(
    input  logic [NIB_W-1:0] i_nib,
    input  logic             i_inv,
    output logic [NIB_W-1:0] o_nib
);

    logic [NIB_W-1:0] w_fwd;
    logic [NIB_W-1:0] w_inv;

    assign w_fwd = sbox_lookup(SBOX_FWD, i_nib);
    assign w_inv = sbox_lookup(SBOX_INV, i_nib);
    assign o_nib = i_inv ? w_inv : w_fwd;

endmodule

// File: rtl/prince_slayer_serial.sv
// Serialized PRINCE substitution layer. The 64-bit state sits in a shift
// register; each BUSY cycle the low NPC nibbles go through the S-boxes and
// re-enter at the top, so after 16/NPC rotations the register holds the
// fully substituted state in its original nibble order.
module prince_slayer_serial
    import prince_pkg::*;
#(
    parameter int NPC = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [STATE_W-1:0] i_in_data,
    input  logic               i_in_inv,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [STATE_W-1:0] o_out_data
);

    localparam int NCYC  = 16 / NPC;
    localparam int SUB_W = NIB_W * NPC;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

    // Reject widths that do not tile the 16-nibble state evenly.
    if (!(NPC == 1 || NPC == 2 || NPC == 4 || NPC == 8 || NPC == 16)) begin : g_bad_npc
        $error("prince_slayer_serial: NPC must be one of 1, 2, 4, 8, 16");
    end

    state_t             r_state;
    logic [STATE_W-1:0] r_sreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_inv;
    logic               r_out_valid;

    logic [SUB_W-1:0]   w_sub;
    logic [STATE_W-1:0] w_next;
    logic               w_in_ready;

    // NPC S-box instances working on the low end of the shift register.
    for (genvar g = 0; g < NPC; g++) begin : g_sbox
        prince_sbox_dual u_sbox (
            .i_nib (r_sreg[g*NIB_W +: NIB_W]),
            .i_inv (r_inv),
            .o_nib (w_sub[g*NIB_W +: NIB_W])
        );
    end

    // Rotate right by SUB_W with the substituted nibbles entering at the top.
    if (NPC == 16) begin : g_full
        assign w_next = w_sub;
    end else begin : g_rot
        assign w_next = {w_sub, r_sreg[STATE_W-1:SUB_W]};
    end

    // A finished block can hand off and accept the next one in the same cycle.
    assign w_in_ready  = (r_state == IDLE) | ((r_state == DONE) & i_out_ready);
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_sreg;

    // Control FSM, shift register, cycle counter and latched mode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_inv       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_sreg  <= i_in_data;
                        r_inv   <= i_in_inv;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_sreg <= w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Result holds until downstream takes it.
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (i_in_valid) begin
                            r_sreg  <= i_in_data;
                            r_inv   <= i_in_inv;
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/prince_slayer_serial.md
Name: prince_slayer_serial

Overview:
- Serialized PRINCE substitution layer on the 64-bit cipher state, with a valid/ready handshake.
- Applies the forward S-box or the inverse S-box to all 16 nibbles, processing NPC nibbles per clock.
- Sits between the round-key/constant XOR stage (upstream) and the M/M' linear layer (downstream).
- Trades area (NPC S-box instances instead of 16) for 16/NPC cycles of latency.

Parameters:
- NPC, default 4: nibbles substituted per clock. Legal values are 1, 2, 4, 8, 16. Any other value is an elaboration error.
- NCYC, derived as 16/NPC: processing cycles per block. It is not user-overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents a state.
- in_ready  out  1  block accepts a state this cycle.
- in_data  in  64  state; nibble i = in_data[4i+3:4i].
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box. Sampled with in_data.
- out_valid  out  1  substituted state available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  64  substituted state, same nibble order as in_data.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state IDLE, out_valid=0, out_data=0, internal counter=0, mode register=0. in_ready=1 immediately after reset deasserts.
- Forward S-box, input 0..F maps to: B F 3 2 A C 9 1 6 7 8 0 E 5 D 4.
- Inverse S-box, input 0..F maps to: B 7 3 2 F D 8 9 A 6 4 0 5 E C 1.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid, load the 64-bit shift register with in_data, latch in_inv, clear the counter, go to BUSY.
- BUSY: in_ready=0, out_valid=0. Each cycle:
  - substitute the low NPC nibbles (bits [4*NPC-1:0]);
  - rotate the register right by 4*NPC bits, with the substituted nibbles entering at the top;
  - increment the counter.
  - When the counter reaches NCYC-1, that cycle's update completes the block; go to DONE.
- After NCYC rotations the register holds the fully substituted state in the original nibble order.
- DONE: out_valid=1, out_data = register, held stable until out_ready.
  - On out_ready alone: go to IDLE.
  - On out_ready and in_valid in the same cycle: in_ready=1. The new block is loaded and the state goes straight to BUSY (no bubble).
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from out_ready; no other combinational in-to-out path exists.
- Latency: data accepted at edge k gives out_valid=1 after edge k+NCYC. Throughput is one block per NCYC+1 cycles when out_ready is held at 1. For NPC=16, NCYC=1.
- Mode: the latched mode applies to the whole block. Changes on in_inv while busy are ignored.
- Backpressure: while DONE with out_ready=0, out_data and out_valid hold. in_valid is ignored.
- Reset mid-operation: rst_n low at any time returns to the reset values asynchronously. The partial block is discarded and no out_valid pulse is produced.
- in_valid while BUSY has no effect. Upstream must hold its data until in_ready.

Decomposition:
- Package prince_pkg holds:
  - the state-width constants STATE_W=64 and NIB_W=4;
  - the forward and inverse S-box constant tables;
  - the FSM state enum {IDLE, BUSY, DONE}.
- One sub-module, prince_sbox_dual: 4-bit combinational forward/inverse S-box with an inv select. It is instantiated NPC times via generate.
- The existing forward-only S-box is reused unchanged elsewhere.

Test Plan:
- NPC=4, forward, in_data=64'h0123456789abcdef accepted at edge 0 -> out_valid at edge 4, out_data=64'hbf32ac916780e5d4.
- NPC=4, inverse, in_data=64'h0123456789abcdef -> out_data=64'hb732fd89a6405ec1.
- Round trip, NPC=1 (16 cycles): forward 64'h0 gives 64'hbbbbbbbbbbbbbbbb. Feeding that result back with inverse gives 64'h0. Check in_ready=0 for exactly 16 cycles of BUSY per block.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0, in_valid ignored. Then out_ready=1 with in_valid=1 -> the next block is accepted in that same cycle.
- Streaming, NPC=16, out_ready=1, in_valid=1 continuously with 4 random states -> 4 results in order, one every 2 cycles, each matching the golden nibble-wise table.
- Reset mid-operation: drop rst_n 2 cycles into BUSY -> out_valid=0, out_data=0, in_ready=1 after release. No stale result appears.
